// File: rtl/serial_multicaster.sv
// Serial command receiver that writes a data word into masked ports of one line
// or all lines, holding port values until the next matching frame.
module serial_multicaster #(
    parameter int unsigned NUM_LINES = 4,
    parameter int unsigned PORTS     = 4,
    parameter int unsigned DATA_W    = 4
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                bitEn,
    input  logic                                serIn,
    output logic [NUM_LINES*PORTS*DATA_W-1:0]   portOut,
    output logic [NUM_LINES-1:0]                lineUpd,
    output logic                                frameErr,
    output logic                                busy
);

    localparam int unsigned LW   = $clog2(NUM_LINES);
    localparam int unsigned MAXF = (LW > PORTS) ? ((LW > DATA_W) ? LW : DATA_W)
                                                : ((PORTS > DATA_W) ? PORTS : DATA_W);
    localparam int unsigned CW   = $clog2(MAXF + 1);

    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] BCAST  = 3'd1;
    localparam logic [2:0] LSEL   = 3'd2;
    localparam logic [2:0] MASK   = 3'd3;
    localparam logic [2:0] DATA   = 3'd4;
    localparam logic [2:0] STOP   = 3'd5;
    localparam logic [2:0] COMMIT = 3'd6;

    logic [2:0]           state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic                 bcast_q, stop_q;
    logic [LW-1:0]        lsel_q;
    logic [PORTS-1:0]     mask_q;
    logic [DATA_W-1:0]    data_q;
    logic [NUM_LINES-1:0] tgt;
    logic                 commit_ok;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            busy  <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            busy  <= (state_next != IDLE);
        end
    end

    // Next state: each field counts down its bit width on bitEn samples
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE:   if (bitEn && !serIn) state_next = BCAST;
            BCAST:  if (bitEn) begin
                        state_next = LSEL;
                        cnt_next   = CW'(LW);
                    end
            LSEL:   if (bitEn) begin
                        if (cnt == CW'(1)) begin
                            state_next = MASK;
                            cnt_next   = CW'(PORTS);
                        end else begin
                            cnt_next = cnt - CW'(1);
                        end
                    end
            MASK:   if (bitEn) begin
                        if (cnt == CW'(1)) begin
                            state_next = DATA;
                            cnt_next   = CW'(DATA_W);
                        end else begin
                            cnt_next = cnt - CW'(1);
                        end
                    end
            DATA:   if (bitEn) begin
                        if (cnt == CW'(1)) begin
                            state_next = STOP;
                            cnt_next   = '0;
                        end else begin
                            cnt_next = cnt - CW'(1);
                        end
                    end
            STOP:   if (bitEn) state_next = COMMIT;
            COMMIT: state_next = (bitEn && !serIn) ? BCAST : IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Target lines and frame validity
    always_comb begin
        tgt = '0;
        for (int l = 0; l < int'(NUM_LINES); l++) begin
            tgt[l] = bcast_q || (lsel_q == LW'(l));
        end
        commit_ok = stop_q && (bcast_q || ({1'b0, lsel_q} < (LW + 1)'(NUM_LINES)));
    end

    // Field shift registers (LSB-first), port registers and commit pulses
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bcast_q  <= 1'b0;
            stop_q   <= 1'b0;
            lsel_q   <= '0;
            mask_q   <= '0;
            data_q   <= '0;
            portOut  <= '0;
            lineUpd  <= '0;
            frameErr <= 1'b0;
        end else begin
            if (bitEn) begin
                case (state)
                    BCAST: bcast_q <= serIn;
                    LSEL:  lsel_q  <= (lsel_q >> 1) | (LW'(serIn) << (LW - 1));
                    MASK:  mask_q  <= (mask_q >> 1) | (PORTS'(serIn) << (PORTS - 1));
                    DATA:  data_q  <= (data_q >> 1) | (DATA_W'(serIn) << (DATA_W - 1));
                    STOP:  stop_q  <= serIn;
                    default: ;
                endcase
            end
            lineUpd  <= '0;
            frameErr <= 1'b0;
            if (state == COMMIT) begin
                if (commit_ok) begin
                    lineUpd <= tgt;
                    for (int l = 0; l < int'(NUM_LINES); l++) begin
                        for (int p = 0; p < int'(PORTS); p++) begin
                            if (tgt[l] && mask_q[p]) begin
                                portOut[(l*PORTS + p)*DATA_W +: DATA_W] <= data_q;
                            end
                        end
                    end
                end else begin
                    frameErr <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_serial_multicaster.sv
// Self-checking bench for serial_multicaster: table of frames plus hand-written
// back-to-back and mid-frame-reset sequences, checked through a scoreboard queue.
module tb_serial_multicaster;

    localparam int unsigned NL = 4;
    localparam int unsigned NP = 4;
    localparam int unsigned DW = 4;
    localparam int unsigned OW = NL*NP*DW;

    logic          clk = 1'b0;
    logic          rst;
    logic          bitEn;
    logic          serIn;
    logic [OW-1:0] portOut;
    logic [NL-1:0] lineUpd;
    logic          frameErr;
    logic          busy;

    serial_multicaster #(.NUM_LINES(NL), .PORTS(NP), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .bitEn(bitEn), .serIn(serIn),
        .portOut(portOut), .lineUpd(lineUpd), .frameErr(frameErr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          bcast;
        logic [1:0]    lsel;
        logic [NP-1:0] mask;
        logic [DW-1:0] data;
        logic          stop;
        int            gap;
        logic [NL-1:0] exp_upd;
        logic          exp_err;
    } vec_t;

    typedef struct {
        logic [OW-1:0] port;
        logic [NL-1:0] upd;
        logic          err;
    } exp_t;

    exp_t          sb[$];
    logic [OW-1:0] model;
    int            errors = 0;
    int            checks = 0;

    task automatic chk(input string name, input logic [OW-1:0] act, input logic [OW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Entry and exit of every send_bit is 1 time unit after a rising edge
    task automatic send_bit(input logic b, input int gap_max);
        int g;
        g = (gap_max > 0) ? int'($urandom_range(gap_max, 0)) : 0;
        repeat (g) begin
            @(posedge clk); #1;
        end
        bitEn = 1'b1;
        serIn = b;
        @(posedge clk); #1;
        bitEn = 1'b0;
        serIn = 1'b1;
    endtask

    task automatic send_frame(input vec_t v);
        exp_t e;
        if (!v.exp_err) begin
            for (int l = 0; l < int'(NL); l++)
                for (int p = 0; p < int'(NP); p++)
                    if ((v.bcast || v.lsel == 2'(l)) && v.mask[p])
                        model[(l*NP + p)*DW +: DW] = v.data;
        end
        e.port = model;
        e.upd  = v.exp_upd;
        e.err  = v.exp_err;
        sb.push_back(e);
        send_bit(1'b0, v.gap);
        send_bit(v.bcast, v.gap);
        for (int i = 0; i < 2; i++) send_bit(v.lsel[i], v.gap);
        for (int i = 0; i < int'(NP); i++) send_bit(v.mask[i], v.gap);
        for (int i = 0; i < int'(DW); i++) send_bit(v.data[i], v.gap);
        send_bit(v.stop, v.gap);
    endtask

    // Scoreboard monitor: every pulse cycle must match the next expected commit
    always @(negedge clk) begin
        if (!rst && (lineUpd != '0 || frameErr)) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_pulse: got lineUpd=%b frameErr=%b expected none at %0t",
                         lineUpd, frameErr, $time);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("lineUpd", OW'(lineUpd), OW'(e.upd));
                chk("frameErr", OW'(frameErr), OW'(e.err));
                chk("portOut", portOut, e.port);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

    vec_t tbl[8];
    vec_t v;

    initial begin
        tbl[0] = '{1'b0, 2'd2, 4'b0101, 4'hA, 1'b1, 0, 4'b0100, 1'b0};
        tbl[1] = '{1'b0, 2'd1, 4'b1000, 4'h7, 1'b1, 0, 4'b0010, 1'b0};
        tbl[2] = '{1'b1, 2'd0, 4'b0111, 4'h3, 1'b1, 0, 4'b1111, 1'b0};
        tbl[3] = '{1'b0, 2'd3, 4'b1111, 4'hF, 1'b0, 0, 4'b0000, 1'b1};
        tbl[4] = '{1'b0, 2'd2, 4'b0101, 4'hA, 1'b1, 5, 4'b0100, 1'b0};
        tbl[5] = '{1'b0, 2'd3, 4'b0000, 4'h5, 1'b1, 3, 4'b1000, 1'b0};
        tbl[6] = '{1'b1, 2'd1, 4'b1111, 4'hE, 1'b0, 5, 4'b0000, 1'b1};
        tbl[7] = '{1'b1, 2'd2, 4'b1001, 4'h6, 1'b1, 4, 4'b1111, 1'b0};

        model = '0;
        rst   = 1'b1;
        bitEn = 1'b0;
        serIn = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_portOut", portOut, '0);
        chk("reset_lineUpd", OW'(lineUpd), '0);
        chk("reset_frameErr", OW'(frameErr), '0);
        chk("reset_busy", OW'(busy), '0);
        rst = 1'b0;
        @(posedge clk); #1;

        foreach (tbl[i]) begin
            send_frame(tbl[i]);
            chk("busy_in_commit", OW'(busy), OW'(1));
            @(posedge clk); #1;
            chk("busy_after_commit", OW'(busy), OW'(0));
            @(posedge clk); #1;
        end

        // Back-to-back: second start bit lands in the COMMIT cycle
        v = '{1'b0, 2'd0, 4'b0001, 4'h9, 1'b1, 0, 4'b0001, 1'b0};
        send_frame(v);
        v = '{1'b0, 2'd3, 4'b1000, 4'hC, 1'b1, 0, 4'b1000, 1'b0};
        send_frame(v);
        @(posedge clk); #1;
        chk("b2b_busy_done", OW'(busy), OW'(0));
        repeat (2) begin
            @(posedge clk); #1;
        end

        // Reset after the 7th frame bit discards the partial frame
        send_bit(1'b0, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b0, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        send_bit(1'b1, 0);
        #2 rst = 1'b1;
        #1;
        chk("midrst_portOut", portOut, '0);
        chk("midrst_busy", OW'(busy), '0);
        chk("midrst_lineUpd", OW'(lineUpd), '0);
        chk("midrst_frameErr", OW'(frameErr), '0);
        model = '0;
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;
        v = '{1'b0, 2'd1, 4'b1111, 4'h6, 1'b1, 0, 4'b0010, 1'b0};
        send_frame(v);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("final_portOut", portOut, model);
        chk("scoreboard_drained", OW'(sb.size()), '0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
